// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// if_fetch_unit_if : IMEM read bus, redirect/stall controls and IF-register
//                    outputs of the dual-issue fetch stage.      Rev 1.0
// ============================================================================
interface if_fetch_unit_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic                 stall;
    logic                 branch_taken;
    logic [0:PC_W-1]      branch_target;
    logic [0:PC_W-1]      imem_addr;
    logic                 imem_rd_en;
    logic [0:INSTR_W-1]   imem_data1;
    logic [0:INSTR_W-1]   imem_data2;
    logic [0:PC_W-1]      PC_out;
    logic [0:INSTR_W-1]   instr1_out;
    logic [0:INSTR_W-1]   instr2_out;
    logic                 find_nop_out;
    logic                 valid_out;

    modport master (
        input  stall, branch_taken, branch_target, imem_data1, imem_data2,
        output imem_addr, imem_rd_en, PC_out, instr1_out, instr2_out,
               find_nop_out, valid_out
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data1, imem_data2,
        input  imem_addr, imem_rd_en, PC_out, instr1_out, instr2_out,
               find_nop_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// if_fetch_unit : dual-issue fetch of even-aligned IMEM pairs with stall hold
//                 buffer and branch redirect.                    Rev 1.0
// ============================================================================
module if_fetch_unit #(
    parameter int                 PC_W      = 9,
    parameter int                 INSTR_W   = 32,
    parameter logic [0:INSTR_W-1] NOP_INSTR = 32'h4020_0000
) (
    input  wire               clk,
    input  wire               rst_n,
    if_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_RUN      = 2'd1,
        S_STALLED  = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [0:PC_W-1]      fetch_pc_q, fetch_pc_d;
    logic [0:PC_W-1]      inflight_pc_q, inflight_pc_d;
    logic                 inflight_odd_q, inflight_odd_d;
    logic                 rd_en_q;
    logic [0:PC_W-1]      hold_pc_q, hold_pc_d;
    logic [0:INSTR_W-1]   hold_i1_q, hold_i1_d;
    logic [0:INSTR_W-1]   hold_i2_q, hold_i2_d;
    logic                 hold_nop_q, hold_nop_d;
    logic                 hold_valid_q, hold_valid_d;

    logic [0:PC_W-1]      w_aligned;
    logic [0:PC_W-1]      w_next_pc;
    logic                 w_launch;
    logic [0:PC_W-1]      w_pc;
    logic [0:INSTR_W-1]   w_i1;
    logic [0:INSTR_W-1]   w_i2;
    logic                 w_nop;
    logic                 w_valid;

    assign w_aligned = {fetch_pc_q[0:PC_W-2], 1'b0};
    assign w_next_pc = w_aligned + PC_W'(2);

    // Presented pair: live IMEM data in RUN, frozen copy in STALLED, bubble otherwise.
    always_comb begin
        w_pc    = '0;
        w_i1    = NOP_INSTR;
        w_i2    = NOP_INSTR;
        w_nop   = 1'b0;
        w_valid = 1'b0;
        case (state_q)
            S_RUN: begin
                w_pc    = inflight_pc_q;
                w_i1    = inflight_odd_q ? NOP_INSTR : bus.imem_data1;
                w_i2    = bus.imem_data2;
                w_nop   = inflight_odd_q;
                w_valid = 1'b1;
            end
            S_STALLED: begin
                w_pc    = hold_pc_q;
                w_i1    = hold_i1_q;
                w_i2    = hold_i2_q;
                w_nop   = hold_nop_q;
                w_valid = hold_valid_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        inflight_pc_d  = inflight_pc_q;
        inflight_odd_d = inflight_odd_q;
        hold_pc_d      = hold_pc_q;
        hold_i1_d      = hold_i1_q;
        hold_i2_d      = hold_i2_q;
        hold_nop_d     = hold_nop_q;
        hold_valid_d   = hold_valid_q;
        w_launch       = 1'b0;
        if (bus.branch_taken) begin
            fetch_pc_d   = bus.branch_target;
            hold_valid_d = 1'b0;
            state_d      = S_REDIRECT;
        end else begin
            case (state_q)
                S_FILL: begin
                    // The first edge after reset only turns the read port on.
                    if (rd_en_q) begin
                        w_launch = 1'b1;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stall) begin
                        hold_pc_d    = w_pc;
                        hold_i1_d    = w_i1;
                        hold_i2_d    = w_i2;
                        hold_nop_d   = w_nop;
                        hold_valid_d = w_valid;
                        state_d      = S_STALLED;
                    end else begin
                        w_launch = 1'b1;
                    end
                end
                S_STALLED, S_REDIRECT: begin
                    if (!bus.stall) begin
                        w_launch = 1'b1;
                        state_d  = S_RUN;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
        if (w_launch) begin
            fetch_pc_d     = w_next_pc;
            inflight_pc_d  = fetch_pc_q;
            inflight_odd_d = fetch_pc_q[PC_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FILL;
            fetch_pc_q     <= '0;
            inflight_pc_q  <= '0;
            inflight_odd_q <= 1'b0;
            rd_en_q        <= 1'b0;
            hold_pc_q      <= '0;
            hold_i1_q      <= NOP_INSTR;
            hold_i2_q      <= NOP_INSTR;
            hold_nop_q     <= 1'b0;
            hold_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_odd_q <= inflight_odd_d;
            rd_en_q        <= 1'b1;
            hold_pc_q      <= hold_pc_d;
            hold_i1_q      <= hold_i1_d;
            hold_i2_q      <= hold_i2_d;
            hold_nop_q     <= hold_nop_d;
            hold_valid_q   <= hold_valid_d;
        end
    end

    assign bus.imem_addr    = w_aligned;
    assign bus.imem_rd_en   = rd_en_q;
    assign bus.PC_out       = w_pc;
    assign bus.instr1_out   = w_i1;
    assign bus.instr2_out   = w_i2;
    assign bus.find_nop_out = w_nop;
    assign bus.valid_out    = w_valid;
endmodule
`default_nettype wire
